// File: rtl/flash_read_arbiter_pkg.sv
// Shared types and widths for the sample-playback flash path.
package audio_pkg;

   typedef enum logic [1:0] {IDLE, READ_HI, READ_LO, DONE} arb_state_t;

   localparam int FLASH_ADDR_W = 22;
   localparam int SAMPLE_W     = 16;
   localparam int SAMPLE_IDX_W = 21;

endpackage

// File: rtl/flash_read_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_picker #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = IDX_W'((int'(ptr) + k) % N);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one 8-bit flash port between playback voices;
// each grant performs two timed byte reads and returns a 16-bit sample.
module flash_read_arbiter
   import audio_pkg::*;
#(
   parameter int N_VOICES    = 4,
   parameter int ADDR_W      = FLASH_ADDR_W,
   parameter int WAIT_CYCLES = 6
) (
   input  logic                             Clk,
   input  logic                             Reset,
   input  logic [N_VOICES-1:0]              req,
   input  logic [N_VOICES*SAMPLE_IDX_W-1:0] req_idx,
   output logic [N_VOICES-1:0]              ack,
   output logic [N_VOICES-1:0]              rd_valid,
   output logic [SAMPLE_W-1:0]              rd_data,
   output logic [ADDR_W-1:0]                flash_addr,
   input  logic [7:0]                       flash_data,
   output logic                             busy
);

   localparam int PTR_W = $clog2(N_VOICES);
   localparam int CNT_W = $clog2(WAIT_CYCLES);

   arb_state_t state, state_nxt;

   logic [PTR_W-1:0]        ptr;
   logic [CNT_W-1:0]        cnt;
   logic [N_VOICES-1:0]     win_grant;
   logic [ADDR_W-1:0]       base;
   logic [7:0]              hi_byte;
   logic [7:0]              lo_byte;
   logic                    last_wait;

   logic [N_VOICES-1:0]     pick_grant;
   logic [PTR_W-1:0]        pick_idx;
   logic                    pick_any;
   logic [SAMPLE_IDX_W-1:0] pick_sample_idx;

   rr_priority_picker #(
      .N     (N_VOICES),
      .IDX_W (PTR_W)
   ) u_picker (
      .req   (req),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign pick_sample_idx = req_idx[int'(pick_idx)*SAMPLE_IDX_W +: SAMPLE_IDX_W];
   assign last_wait       = (cnt == CNT_W'(WAIT_CYCLES - 1));

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      flash_addr = '0;
      busy       = (state != IDLE);
      case (state)
         IDLE:    if (pick_any) state_nxt = READ_HI;
         READ_HI: begin
            flash_addr = base;
            if (last_wait) state_nxt = READ_LO;
         end
         READ_LO: begin
            flash_addr = base + ADDR_W'(1);
            if (last_wait) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control: pointer, wait counter, handshake pulses and the returned sample
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ptr       <= '0;
         cnt       <= '0;
         ack       <= '0;
         rd_valid  <= '0;
         rd_data   <= '0;
         win_grant <= '0;
      end else begin
         ack      <= '0;
         rd_valid <= '0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (pick_any) begin
                  ack       <= pick_grant;
                  win_grant <= pick_grant;
                  ptr       <= (pick_idx == PTR_W'(N_VOICES - 1)) ? '0 : pick_idx + 1'b1;
               end
            end
            READ_HI, READ_LO: cnt <= last_wait ? '0 : cnt + 1'b1;
            DONE: begin
               rd_data  <= {hi_byte, lo_byte};
               rd_valid <= win_grant;
            end
            default: cnt <= '0;
         endcase
      end
   end

   // Data capture: address base and flash bytes carry no reset
   always_ff @(posedge Clk) begin
      if (state == IDLE && pick_any)
         base <= ADDR_W'({pick_sample_idx, 1'b0});
      if (state == READ_HI && last_wait)
         hi_byte <= flash_data;
      if (state == READ_LO && last_wait)
         lo_byte <= flash_data;
   end

endmodule
